mem_view_step_ctrl: RTL and testbench

Step controller placed directly upstream of the memory-viewer LED stage. It turns three board push-buttons into a 9-bit display index, and can either auto-advance at a slow, human-readable rate or step one position per press. The index packs three fields: memory select (bit 8: 0 = instruction, 1 = data), word address (bits 7:1) and halfword select (bit 0: 0 = bits 31:16, 1 = bits 15:0). The downstream stage consumes this index in place of its free-running per-clock counter.

---
 rtl/mem_view_step_ctrl_pkg.sv | 23 ++
 rtl/mem_view_step_ctrl_if.sv | 31 +++
 rtl/mem_view_step_ctrl_btn_debounce.sv | 45 ++++
 rtl/mem_view_step_ctrl.sv | 91 +++++++++
 tb/tb_mem_view_step_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_view_step_ctrl_pkg.sv
// Shared definitions for the memory-viewer step controller: FSM states,
// display-index width and field layout, and the index advance helper.
package mem_view_step_ctrl_pkg;

    typedef enum logic [0:0] {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int IDX_W = 9;

    // idx layout: {mem_sel, word[6:0], half}
    localparam int MEM_SEL_BIT = 8;
    localparam int WORD_MSB    = 7;
    localparam int WORD_LSB    = 1;
    localparam int HALF_BIT    = 0;

    // Free-running advance; 511 rolls over to 0 so the viewer cycles forever.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
        return v + IDX_W'(1);
    endfunction

endpackage

// File: rtl/mem_view_step_ctrl_if.sv
// Button inputs and display-index outputs of the step controller, bundled
// so the controller and the LED stage share one connection point.
interface mem_view_step_ctrl_if;
    import mem_view_step_ctrl_pkg::*;

    logic             btn_run;
    logic             btn_step;
    logic             btn_clear;
    logic [IDX_W-1:0] idx;
    logic             idx_stb;
    logic             running;

    modport slave (
        input  btn_run,
        input  btn_step,
        input  btn_clear,
        output idx,
        output idx_stb,
        output running
    );

    modport master (
        output btn_run,
        output btn_step,
        output btn_clear,
        input  idx,
        input  idx_stb,
        input  running
    );

endinterface

// File: rtl/mem_view_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, consecutive-sample debounce
// and a registered one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYC);

    logic             s1;
    logic             s2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any sample agreeing with the accepted level restarts the run.
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYC - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/mem_view_step_ctrl.sv
// Step controller feeding the memory-viewer LED stage: debounced buttons
// drive a RUN/PAUSE FSM, a slow tick divider and the 9-bit display index.
module mem_view_step_ctrl
    import mem_view_step_ctrl_pkg::*;
#(
    parameter int STEP_DIV = 50_000_000,
    parameter int DB_CYC   = 1_000_000
) (
    input logic                  clk,
    input logic                  reset,
    mem_view_step_ctrl_if.slave  bus
);

    localparam int TW = $clog2(STEP_DIV);
    localparam logic [0:0] S_PAUSE = 1'(PAUSE);
    localparam logic [0:0] S_RUN   = 1'(RUN);

    logic             press_run;
    logic             press_step;
    logic             press_clear;
    logic [2:0]       level_unused;
    logic [0:0]       state;
    logic [TW-1:0]    tcnt;
    logic             tick;
    logic [IDX_W-1:0] idx_r;
    logic             stb_r;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_run (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_run),
        .level (level_unused[0]),
        .press (press_run)
    );

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_step (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_step),
        .level (level_unused[1]),
        .press (press_step)
    );

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_clear (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_clear),
        .level (level_unused[2]),
        .press (press_clear)
    );

    assign tick = (state == S_RUN) && (tcnt == TW'(STEP_DIV - 1));

    // Held at 0 while paused so the first tick lands STEP_DIV edges after RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (press_clear || (state == S_PAUSE) || tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // Priority clear > run > step/tick; a run press swallows a coincident advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_PAUSE;
            idx_r <= '0;
            stb_r <= 1'b0;
        end else begin
            stb_r <= 1'b0;
            if (press_clear) begin
                idx_r <= '0;
                stb_r <= 1'b1;
            end else if (!press_run &&
                         (((state == S_PAUSE) && press_step) || tick)) begin
                idx_r <= idx_inc(idx_r);
                stb_r <= 1'b1;
            end
            if (press_run) begin
                state <= ~state;
            end
        end
    end

    assign bus.idx     = idx_r;
    assign bus.idx_stb = stb_r;
    assign bus.running = (state == S_RUN);

endmodule

// File: tb/tb_mem_view_step_ctrl.sv
// Directed bench for mem_view_step_ctrl with short debounce/tick periods.
module tb_mem_view_step_ctrl;
    import mem_view_step_ctrl_pkg::*;

    localparam int STEP_DIV = 5;
    localparam int DB_CYC   = 4;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   now = 0;
    int   stb_seen = 0;
    int   dbl = 0;
    int   seen0;
    logic stb_prev = 1'b0;
    logic [IDX_W-1:0] idx_v;

    mem_view_step_ctrl_if vif ();

    mem_view_step_ctrl #(.STEP_DIV(STEP_DIV), .DB_CYC(DB_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vif.idx_stb && stb_prev) dbl++;
        if (vif.idx_stb) stb_seen++;
        stb_prev = vif.idx_stb;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_to(input int e);
        while (now < e) begin
            @(posedge clk);
            now++;
        end
        #1;
    endtask

    task automatic origin();
        @(posedge clk);
        now = 0;
        #1;
    endtask

    task automatic step_press();
        origin();
        vif.btn_step = 1'b1;
        tick_to(10);
        vif.btn_step = 1'b0;
        tick_to(20);
    endtask

    initial begin
        reset         = 1'b0;
        vif.btn_run   = 1'b0;
        vif.btn_step  = 1'b0;
        vif.btn_clear = 1'b0;

        // Reset state and idle after release
        #23;
        check("rst_idx", vif.idx, 0);
        check("rst_stb", vif.idx_stb, 0);
        check("rst_running", vif.running, 0);
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("idle_idx", vif.idx, 0);
        check("idle_stb", vif.idx_stb, 0);
        check("idle_running", vif.running, 0);

        // First step press: latency DB_CYC+4 edges
        origin();
        vif.btn_step = 1'b1;
        tick_to(7);
        check("step_e7_idx", vif.idx, 0);
        check("step_e7_stb", vif.idx_stb, 0);
        tick_to(8);
        check("step_e8_idx", vif.idx, 1);
        check("step_e8_stb", vif.idx_stb, 1);
        tick_to(9);
        check("step_e9_stb", vif.idx_stb, 0);
        vif.btn_step = 1'b0;
        tick_to(20);
        check("step_release_idx", vif.idx, 1);

        // 510 more presses reach 511, one more wraps to 0
        for (int i = 0; i < 510; i++) step_press();
        check("step_511", vif.idx, 511);
        idx_v = vif.idx;
        check("field_mem_sel", idx_v[MEM_SEL_BIT], 1);
        check("field_word", idx_v[WORD_MSB:WORD_LSB], 127);
        check("field_half", idx_v[HALF_BIT], 1);
        step_press();
        check("step_wrap", vif.idx, 0);

        // Bounce shorter than DB_CYC is rejected
        seen0 = stb_seen;
        for (int i = 0; i < 5; i++) begin
            vif.btn_step = 1'b1;
            repeat (3) @(posedge clk);
            vif.btn_step = 1'b0;
            repeat (3) @(posedge clk);
        end
        repeat (15) @(posedge clk);
        #1;
        check("bounce_idx", vif.idx, 0);
        check("bounce_stb_count", stb_seen - seen0, 0);

        // Auto-run: enter RUN at edge 8, ticks at 13, 18, 23, ...
        origin();
        vif.btn_run = 1'b1;
        tick_to(7);
        check("run_e7_running", vif.running, 0);
        tick_to(8);
        check("run_e8_running", vif.running, 1);
        check("run_e8_stb", vif.idx_stb, 0);
        tick_to(9);
        vif.btn_run = 1'b0;
        tick_to(12);
        check("run_e12_idx", vif.idx, 0);
        tick_to(13);
        check("run_e13_idx", vif.idx, 1);
        check("run_e13_stb", vif.idx_stb, 1);
        tick_to(14);
        check("run_e14_stb", vif.idx_stb, 0);
        tick_to(18);
        check("run_e18_idx", vif.idx, 2);
        tick_to(23);
        check("run_e23_idx", vif.idx, 3);
        tick_to(24);
        vif.btn_step = 1'b1;
        tick_to(28);
        check("run_e28_idx", vif.idx, 4);
        tick_to(32);
        check("run_step_ignored_idx", vif.idx, 4);
        check("run_step_ignored_stb", vif.idx_stb, 0);
        vif.btn_step = 1'b0;
        tick_to(33);
        check("run_e33_idx", vif.idx, 5);
        tick_to(36);
        vif.btn_run = 1'b1;
        tick_to(38);
        check("run_e38_idx", vif.idx, 6);
        tick_to(43);
        check("run_e43_idx", vif.idx, 7);
        check("run_e43_running", vif.running, 1);
        tick_to(44);
        check("pause_e44_running", vif.running, 0);
        check("pause_e44_idx", vif.idx, 7);
        tick_to(45);
        vif.btn_run = 1'b0;
        tick_to(70);
        check("pause_frozen_idx", vif.idx, 7);
        check("pause_frozen_running", vif.running, 0);

        // Clear coinciding with a tick at edge 163 (idx 37)
        origin();
        vif.btn_run = 1'b1;
        tick_to(8);
        check("clr_run_running", vif.running, 1);
        check("clr_run_idx", vif.idx, 7);
        tick_to(9);
        vif.btn_run = 1'b0;
        tick_to(155);
        vif.btn_clear = 1'b1;
        tick_to(162);
        check("clr_pre_idx", vif.idx, 37);
        tick_to(163);
        check("clr_idx", vif.idx, 0);
        check("clr_stb", vif.idx_stb, 1);
        check("clr_running", vif.running, 1);
        tick_to(164);
        vif.btn_clear = 1'b0;
        tick_to(167);
        check("clr_e167_idx", vif.idx, 0);
        tick_to(168);
        check("clr_e168_idx", vif.idx, 1);
        check("clr_e168_stb", vif.idx_stb, 1);

        // Asynchronous reset at a clock midpoint with idx = 200
        tick_to(1165);
        check("pre_areset_idx", vif.idx, 200);
        check("pre_areset_running", vif.running, 1);
        #4;
        reset = 1'b0;
        #1;
        check("areset_idx", vif.idx, 0);
        check("areset_running", vif.running, 0);
        check("areset_stb", vif.idx_stb, 0);
        #10;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_double_stb", dbl, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
